x_counter_4_bit_ctrl: RTL and testbench
=======================================

Name: x_counter_4_bit_ctrl

Overview:
- Sequencing controller for a 4-bit binary counter.
- Turns the counter into a start/stop programmable-period timer with one-shot and periodic modes.
- Flags terminal count with a single-cycle done pulse.
- Count state is exposed bit-per-port so downstream discrete logic (LED drivers, decoders) can tap individual bits.

Parameters:
- None. Count width is fixed at 4 bits; period range is 0..15.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_rst  input  1  asynchronous, active-high reset.
- i_start  input  1  start request; level sampled on each rising edge.
- i_stop  input  1  abort request; level sampled on each rising edge.
- i_periodic  input  1  1 = auto-restart at terminal count; 0 = one-shot. Sampled with i_start.
- i_period_3..i_period_0  input  1 each  terminal count value P, MSB first. Sampled with i_start.
- o_busy  output  1  high while in RUN.
- o_done  output  1  one-cycle pulse after terminal count.
- o_count_3..o_count_0  output  1 each  current count, MSB first.

Behaviour:
- Registered state:
  - fsm state: IDLE or RUN.
  - count_q: 4 bits.
  - period_q: 4 bits, latched P.
  - periodic_q: 1 bit.
  - done_q: 1 bit.
- All outputs come straight from flops; no combinational input-to-output paths.
- Reset (i_rst high, asynchronous, at any time including mid-run):
  - state = IDLE.
  - count_q, period_q, periodic_q, done_q, o_busy all = 0.
  - All outputs read 0 while reset is asserted and until the first edge after release.
- IDLE:
  - count_q held at 0; o_busy = 0.
  - Edge with i_start=1 and i_stop=0:
    - period_q <= P; periodic_q <= i_periodic; count_q <= 0.
    - state <= RUN.
  - Edge with i_start=1 and i_stop=1: stop wins; stay IDLE.
- RUN, evaluated per edge in priority order:
  1. i_stop=1: state <= IDLE, count_q <= 0, done_q <= 0. Abort gives no done pulse.
  2. count_q == period_q (terminal): done_q <= 1, count_q <= 0.
     - If periodic_q = 1: stay RUN.
     - If periodic_q = 0: state <= IDLE.
  3. Otherwise: count_q <= count_q + 1, done_q <= 0.
- i_start while in RUN is ignored. No restart and no re-latch of P or mode.
- done_q clears on the next edge unless terminal is hit again.
- Timing for a start sampled at edge k:
  - Count reads 0 after edge k, then 1..P after edges k+1..k+P.
  - Terminal is detected at edge k+P+1; o_done is high for the cycle after edge k+P+1.
  - One-shot: o_busy high for exactly P+1 cycles; o_busy falls on the same edge that o_done rises.
  - Periodic: o_done pulses every P+1 cycles. Count sequence is 0..P repeating.
- P = 0:
  - One-shot: busy for 1 cycle, then done.
  - Periodic: count stays 0 and o_done stays high every cycle until stopped.
- Wrap-around: count never passes period_q, so the 4-bit count never wraps from 15 to 0 by increment. P = 15 reaches 15, then returns to 0 via the terminal rule.
- Re-start after a one-shot: i_start sampled on the same edge that o_done rises (first IDLE cycle) takes effect on the next edge. Minimum restart gap is 1 cycle.
- Changes on i_period_* or i_periodic after the start edge have no effect until the next start.

Test Plan:
- Reset then hold idle:
  - Assert i_rst mid-cycle with no clock edge → all outputs 0 immediately.
  - Release, drive i_start=0 for 5 cycles → count stays 0, o_busy=0, o_done=0.
- One-shot, P=5:
  - Start pulse → count 0,1,2,3,4,5 with o_busy high for 6 cycles.
  - Then o_done=1 for exactly 1 cycle with count=0, o_busy=0.
- Periodic, P=3, run 12 cycles:
  - Count 0,1,2,3,0,1,2,3,0,…
  - o_done high in the cycle after each count=3; 3 pulses total.
  - o_busy stays 1 throughout.
- Abort:
  - Periodic P=15; assert i_stop when count=7 → next cycle count=0, o_busy=0, o_done never asserted.
  - Simultaneous i_start=1, i_stop=1 from IDLE → stays IDLE.
- Boundaries:
  - P=0 one-shot → busy 1 cycle, then done.
  - P=0 periodic → o_done high every cycle.
  - P=15 one-shot → count reaches 15, then done, with no wrap before terminal.
  - Change i_period to 2 mid-run → no effect.
- Async reset mid-run:
  - P=9 periodic; assert i_rst at count=6 between edges → outputs 0 immediately.
  - After release with no new start, block remains IDLE.

Source files
------------

// File: rtl/x_counter_4_bit_ctrl.sv
// Start/stop programmable-period timer around a 4-bit counter.
// One-shot or periodic operation with a single-cycle done pulse at terminal count.
module x_counter_4_bit_ctrl (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_stop,
  input  logic i_periodic,
  input  logic i_period_3,
  input  logic i_period_2,
  input  logic i_period_1,
  input  logic i_period_0,
  output logic o_busy,
  output logic o_done,
  output logic o_count_3,
  output logic o_count_2,
  output logic o_count_1,
  output logic o_count_0
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] count_q, count_d;
  logic [3:0] period_q, period_d;
  logic       periodic_q, periodic_d;
  logic       done_q, done_d;
  logic       busy_q, busy_d;
  logic [3:0] period_in_s;

  assign period_in_s = {i_period_3, i_period_2, i_period_1, i_period_0};

  // Next-state decode: stop beats terminal, terminal beats increment.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    period_d   = period_q;
    periodic_d = periodic_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      ST_IDLE: begin
        count_d = 4'd0;
        if (i_start && !i_stop) begin
          period_d   = period_in_s;
          periodic_d = i_periodic;
          state_d    = ST_RUN;
          busy_d     = 1'b1;
        end else begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      ST_RUN: begin
        if (i_stop) begin
          state_d = ST_IDLE;
          count_d = 4'd0;
          busy_d  = 1'b0;
        end else if (count_q == period_q) begin
          done_d  = 1'b1;
          count_d = 4'd0;
          if (periodic_q) begin
            state_d = ST_RUN;
            busy_d  = 1'b1;
          end else begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end
        end else begin
          count_d = count_q + 4'd1;
          busy_d  = 1'b1;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        count_d    = 4'd0;
        period_d   = 4'd0;
        periodic_d = 1'b0;
        busy_d     = 1'b0;
      end
    endcase
  end

  // State and output registers; busy is kept as its own flop so outputs stay flop-driven.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      count_q    <= 4'd0;
      period_q   <= 4'd0;
      periodic_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      period_q   <= period_d;
      periodic_q <= periodic_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_count_3 = count_q[3];
  assign o_count_2 = count_q[2];
  assign o_count_1 = count_q[1];
  assign o_count_0 = count_q[0];

endmodule

// File: tb/tb_x_counter_4_bit_ctrl.sv
// Bench for x_counter_4_bit_ctrl: directed scenarios plus random traffic,
// checked every cycle against an elapsed-time model of the timer.
module tb_x_counter_4_bit_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic       periodic = 1'b0;
  logic [3:0] per_in = 4'd0;
  logic       busy, done, c3, c2, c1, c0;
  logic [3:0] cnt;

  assign cnt = {c3, c2, c1, c0};

  x_counter_4_bit_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_stop(stop),
    .i_periodic(periodic),
    .i_period_3(per_in[3]), .i_period_2(per_in[2]),
    .i_period_1(per_in[1]), .i_period_0(per_in[0]),
    .o_busy(busy), .o_done(done),
    .o_count_3(c3), .o_count_2(c2), .o_count_1(c1), .o_count_0(c0)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Model: time elapsed since the start edge determines everything.
  bit m_act = 1'b0;
  int m_el = 0;
  int m_p = 0;
  bit m_per = 1'b0;
  bit m_done = 1'b0;

  function automatic int m_count();
    return m_act ? (m_el % (m_p + 1)) : 0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit nd;
    nd = 1'b0;
    if (m_act) begin
      if (stop) begin
        m_act = 1'b0;
      end else begin
        m_el++;
        if (m_el % (m_p + 1) == 0) begin
          nd = 1'b1;
          if (!m_per) m_act = 1'b0;
        end
      end
    end else if (start && !stop) begin
      m_act = 1'b1;
      m_el  = 0;
      m_p   = int'(per_in);
      m_per = periodic;
    end
    m_done = nd;
  endtask

  task automatic check_model();
    chk("count", 32'(cnt), 32'(m_count()));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
  endtask

  // Drive at negedge, let the edge happen, then compare at the next negedge.
  task automatic step(input bit s, input bit p, input bit pe, input logic [3:0] pv);
    start = s; stop = p; periodic = pe; per_in = pv;
    @(posedge clk);
    if (!rst) model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, periodic, per_in);
  endtask

  task automatic rst_pulse();
    #2 rst = 1'b1;
    #1;
    chk("rst_async_count", 32'(cnt), 32'd0);
    chk("rst_async_busy", 32'(busy), 32'd0);
    chk("rst_async_done", 32'(done), 32'd0);
    m_act = 1'b0; m_el = 0; m_p = 0; m_per = 1'b0; m_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_model();
    rst = 1'b0;
  endtask

  int pulses;

  initial begin
    @(negedge clk);
    rst_pulse();
    for (int i = 0; i < 5; i++) idle();

    // One-shot P=5
    step(1'b1, 1'b0, 1'b0, 4'd5);
    chk("p5_first", 32'(cnt), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      idle();
      chk("p5_count", 32'(cnt), 32'(i));
      chk("p5_busy", 32'(busy), 32'd1);
    end
    idle();
    chk("p5_done", 32'(done), 32'd1);
    chk("p5_busy_off", 32'(busy), 32'd0);
    idle();
    chk("p5_done_off", 32'(done), 32'd0);

    // Periodic P=3
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 4'd3);
    for (int i = 0; i < 12; i++) begin
      idle();
      if (done) pulses++;
      chk("p3_busy", 32'(busy), 32'd1);
    end
    chk("p3_pulses", 32'(pulses), 32'd3);
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // Abort at count 7, P=15 periodic
    pulses = 0;
    step(1'b1, 1'b0, 1'b1, 4'd15);
    for (int i = 0; i < 7; i++) begin
      idle();
      if (done) pulses++;
    end
    chk("abort_at7", 32'(cnt), 32'd7);
    step(1'b0, 1'b1, 1'b1, 4'd15);
    chk("abort_count", 32'(cnt), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    if (done) pulses++;
    idle();
    if (done) pulses++;
    chk("abort_no_done", 32'(pulses), 32'd0);

    // Start and stop together from IDLE
    step(1'b1, 1'b1, 1'b0, 4'd4);
    chk("startstop_busy", 32'(busy), 32'd0);
    idle();

    // P=0 one-shot
    step(1'b1, 1'b0, 1'b0, 4'd0);
    chk("p0_busy", 32'(busy), 32'd1);
    idle();
    chk("p0_done", 32'(done), 32'd1);
    chk("p0_idle", 32'(busy), 32'd0);
    idle();

    // P=0 periodic
    step(1'b1, 1'b0, 1'b1, 4'd0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("p0per_done", 32'(done), 32'd1);
    end
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // P=15 one-shot
    step(1'b1, 1'b0, 1'b0, 4'd15);
    for (int i = 0; i < 15; i++) idle();
    chk("p15_top", 32'(cnt), 32'd15);
    idle();
    chk("p15_done", 32'(done), 32'd1);
    chk("p15_wrap", 32'(cnt), 32'd0);

    // Period change mid-run has no effect
    step(1'b1, 1'b0, 1'b0, 4'd4);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 4'd2);
    chk("relatch_count", 32'(cnt), 32'd4);
    step(1'b1, 1'b0, 1'b1, 4'd2);
    chk("relatch_done", 32'(done), 32'd1);
    // Restart on the first idle cycle
    step(1'b1, 1'b0, 1'b0, 4'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    idle(); idle();

    // Async reset mid-run
    step(1'b1, 1'b0, 1'b1, 4'd9);
    for (int i = 0; i < 6; i++) idle();
    chk("ar_at6", 32'(cnt), 32'd6);
    rst_pulse();
    for (int i = 0; i < 3; i++) begin
      idle();
      chk("ar_idle", 32'(busy), 32'd0);
    end

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 59) == 0) rst_pulse();
      else step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0,
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
